// File: rtl/shifter_arbiter.sv
// Two-requester round-robin arbiter in front of one shared W-bit barrel rotator.
// Grants one requester, latches its operands, rotates, and returns a registered result.
module shifter_arbiter #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic [W-1:0]  a0,
  input  logic [AW-1:0] amt0,
  input  logic          dir0,
  input  logic          req1,
  input  logic [W-1:0]  a1,
  input  logic [AW-1:0] amt1,
  input  logic          dir1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [W-1:0]  y,
  output logic          owner,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_gnt0, r_gnt1, r_done0, r_done1, r_busy;
  logic          r_owner, r_ptr;
  logic [W-1:0]  r_y;
  logic [W-1:0]  r_a_p0;
  logic [AW-1:0] r_amt_p0;
  logic          r_dir_p0;

  logic          w_take, w_win;
  logic          w_gnt0_nxt, w_gnt1_nxt, w_done0_nxt, w_done1_nxt;

  // Rotating a doubled copy keeps the wrapped-around bits without a W-amt term.
  function automatic logic [W-1:0] rot_f(input logic [W-1:0] a,
                                         input logic [AW-1:0] amt,
                                         input logic dir);
    logic [2*W-1:0] d;
    d = {a, a};
    if (dir) begin
      d = d << amt;
      return d[2*W-1:W];
    end else begin
      d = d >> amt;
      return d[W-1:0];
    end
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_win       = 1'b0;
    w_gnt0_nxt  = 1'b0;
    w_gnt1_nxt  = 1'b0;
    w_done0_nxt = 1'b0;
    w_done1_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (req0 || req1) begin
          w_win       = (req0 && req1) ? r_ptr : req1;
          w_take      = 1'b1;
          w_gnt0_nxt  = ~w_win;
          w_gnt1_nxt  = w_win;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        w_done0_nxt = ~r_owner;
        w_done1_nxt = r_owner;
        w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_busy  <= 1'b0;
      r_owner <= 1'b0;
      r_ptr   <= 1'b0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt0  <= w_gnt0_nxt;
      r_gnt1  <= w_gnt1_nxt;
      r_done0 <= w_done0_nxt;
      r_done1 <= w_done1_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      if (w_take) r_owner <= w_win;
      if (r_state == EXEC) begin
        r_y   <= rot_f(r_a_p0, r_amt_p0, r_dir_p0);
        r_ptr <= ~r_owner;
      end
    end
  end

  // Operand capture at grant time; later operand changes cannot reach the rotator.
  always_ff @(posedge clk) begin
    if (w_take) begin
      r_a_p0   <= w_win ? a1   : a0;
      r_amt_p0 <= w_win ? amt1 : amt0;
      r_dir_p0 <= w_win ? dir1 : dir0;
    end
  end

  assign gnt0  = r_gnt0;
  assign gnt1  = r_gnt1;
  assign done0 = r_done0;
  assign done1 = r_done1;
  assign y     = r_y;
  assign owner = r_owner;
  assign busy  = r_busy;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed bench for shifter_arbiter: hand-computed rotate results, grant order and reset abort.
module tb_shifter_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] a0 = '0, a1 = '0;
  logic [2:0] amt0 = '0, amt1 = '0;
  logic       dir0 = 1'b0, dir1 = 1'b0;
  logic       gnt0, gnt1, done0, done1, owner, busy;
  logic [7:0] y;

  int n_tests = 0;
  int n_fail  = 0;

  shifter_arbiter #(.W(8), .AW(3)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .amt0(amt0), .dir0(dir0),
    .req1(req1), .a1(a1), .amt1(amt1), .dir1(dir1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .y(y), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One solo operation from requester r; req is dropped right after the grant.
  task automatic solo_op(input logic r, input logic [7:0] a, input logic [2:0] amt,
                         input logic dir, input logic [7:0] exp_y);
    if (r) begin req1 = 1'b1; a1 = a; amt1 = amt; dir1 = dir; end
    else   begin req0 = 1'b1; a0 = a; amt0 = amt; dir0 = dir; end
    tick();
    check("gnt0", gnt0, !r);
    check("gnt1", gnt1, r);
    check("busy_exec", busy, 1);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    check("done0", done0, !r);
    check("done1", done1, r);
    check("y", y, exp_y);
    check("owner", owner, r);
    check("busy_done", busy, 1);
    check("gnt_drop", {gnt0, gnt1}, 0);
    tick();
    check("done_drop", {done0, done1}, 0);
    check("busy_idle", busy, 0);
  endtask

  logic [7:0] rot_tab [1:7];

  initial begin
    rot_tab[1] = 8'b11100111; rot_tab[2] = 8'b11001111; rot_tab[3] = 8'b10011111;
    rot_tab[4] = 8'b00111111; rot_tab[5] = 8'b01111110; rot_tab[6] = 8'b11111100;
    rot_tab[7] = 8'b11111001;

    tick(); tick();
    reset = 1'b0;
    check("rst_outs", {gnt0, gnt1, done0, done1, owner, busy}, 0);
    check("rst_y", y, 0);

    solo_op(1'b0, 8'b11010111, 3'd3, 1'b0, 8'b11111010);

    for (int i = 1; i <= 7; i++)
      solo_op(1'b1, 8'b11110011, 3'(i), 1'b1, rot_tab[i]);

    // Both requesters held from reset: grants alternate 0,1,0,1, three cycles apart.
    reset = 1'b1; tick(); reset = 1'b0;
    req0 = 1'b1; a0 = 8'h81; amt0 = 3'd1; dir0 = 1'b0;
    req1 = 1'b1; a1 = 8'h0F; amt1 = 3'd2; dir1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic w;
      w = 1'(i % 2);
      tick();
      check("fair_gnt0", gnt0, !w);
      check("fair_gnt1", gnt1, w);
      tick();
      check("fair_done", {done1, done0}, w ? 2'b10 : 2'b01);
      check("fair_y", y, w ? 8'h3C : 8'hC0);
      check("fair_owner", owner, w);
      tick();
      check("fair_gap", {gnt0, gnt1}, 0);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick(); tick();

    // Operand change after grant must not affect the result.
    req1 = 1'b1; a1 = 8'h3C; amt1 = 3'd2; dir1 = 1'b0;
    tick();
    check("latch_gnt1", gnt1, 1);
    req1 = 1'b0; a1 = 8'hFF; amt1 = 3'd5; dir1 = 1'b1;
    tick();
    check("latch_y", y, 8'h0F);
    check("latch_done1", done1, 1);
    tick();

    solo_op(1'b0, 8'b00000001, 3'd0, 1'b0, 8'b00000001);
    solo_op(1'b0, 8'b00000001, 3'd1, 1'b0, 8'b10000000);

    // Reset during EXEC: no done, outputs cleared, pointer back to requester 0.
    req0 = 1'b1; a0 = 8'h12; amt0 = 3'd1; dir0 = 1'b1;
    tick();
    check("abort_gnt0", gnt0, 1);
    req0 = 1'b0;
    reset = 1'b1;
    tick();
    check("abort_done", {done0, done1}, 0);
    check("abort_y", y, 0);
    check("abort_busy", busy, 0);
    check("abort_owner", owner, 0);
    reset = 1'b0;
    tick();
    check("abort_nodone", {done0, done1}, 0);
    req0 = 1'b1; req1 = 1'b1; a1 = 8'hAA;
    tick();
    check("post_gnt0", gnt0, 1);
    check("post_gnt1", gnt1, 0);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    check("post_done0", done0, 1);
    check("post_y", y, 8'h24);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
